pm_loader: RTL and testbench
============================

Name: pm_loader

Overview:
- Host-side writer for the 256x8 program memory: accepts a byte stream over a valid/ready handshake and writes it into program memory from address 0.
- Holds the microprocessor in reset while loading and releases it only after an additive checksum passes.
- Sits between the host interface and the program memory's write port, alongside the microprocessor top.

Parameters:
ADDR_W, 8, program memory address width (depth = 2**ADDR_W)
DATA_W, 8, program memory word / stream byte width

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a load
rx_data  input  DATA_W  stream byte from host
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts a byte this cycle
pm_wr_addr  output  ADDR_W  program memory write address (registered)
pm_wr_data  output  DATA_W  program memory write data (registered)
pm_wren  output  1  program memory write enable (registered, 1-cycle pulse)
cpu_reset  output  1  reset request to the microprocessor
busy  output  1  load in progress
done  output  1  last load passed its checksum (sticky)
error  output  1  last load failed its checksum (sticky)

Behaviour:
- Interface: one clock `clk`; asynchronous active-high `reset`.
- Reset values: state=IDLE, rx_ready=0, pm_wren=0, pm_wr_addr=0, pm_wr_data=0, cpu_reset=1, busy=0, done=0, error=0, internal count/sum=0.
- Transfer occurs on a rising edge where rx_valid and rx_ready are both 1. rx_ready is a function of state only and never of rx_valid.
- Stream format: LEN byte, then N data bytes, then CHK byte. LEN=0 means N=256; otherwise N=LEN.
- IDLE: rx_ready=0, busy=0.
  - start=1 moves to LEN on the next edge.
  - In the same edge: cpu_reset=1, done=0, error=0, sum=0, addr=0.
- LEN: rx_ready=1, busy=1. On transfer, latch the remaining count (N) and move to LOAD.
- LOAD: rx_ready=1, busy=1. On each transfer:
  - The next cycle has pm_wren=1, pm_wr_addr=addr, pm_wr_data=byte (write latency 1 cycle, pulse exactly 1 cycle).
  - addr increments modulo 2**ADDR_W. sum = (sum + byte) mod 2**DATA_W. remaining decrements.
  - When the transfer takes remaining from 1 to 0, move to CHECK.
- CHECK: rx_ready=1, busy=1. On transfer:
  - If (sum + CHK) mod 256 == 0: move to IDLE with done=1 and cpu_reset=0.
  - Otherwise move to IDLE with error=1 and cpu_reset held at 1.
- Boundary conditions:
  - start while busy: ignored.
  - start while rx_valid is high in IDLE: the byte is not consumed.
  - Gaps in rx_valid: state holds and no write occurs.
  - LEN=0: addresses 0..255 are written, and addr wraps 255→0 on the final byte.
  - After a failed load, the processor stays in reset until a later load passes.
- Reset mid-load: everything returns immediately (asynchronously) to the reset values. A pm_wren pulse in flight is cancelled. Memory contents are left as written.
- cpu_reset deasserts on the same edge that sets done. It is driven from a flop; no glitches.

Decomposition:
- Shared package `pm_loader_pkg`:
  - state enum {IDLE, LEN, LOAD, CHECK}
  - LEN_FULL_DEPTH = 0
  - CHK_OK = 0
- No sub-module; a single FSM plus a datapath of addr, remaining, sum and the write-port registers.

Test Plan:
- Basic load: after reset, start; send LEN=3, bytes 0x12, 0x34, 0x56, CHK=0x64. Expect:
  - writes (0,0x12), (1,0x34), (2,0x56), each pm_wren a 1-cycle pulse one cycle after its transfer;
  - done=1, error=0, cpu_reset=0.
- Bad checksum: same stream with CHK=0x65. Expect error=1, done=0, cpu_reset=1; the three writes still occurred.
- Handshake stalls: LEN=2, data 0xA0, 0x60, CHK=0x00, with rx_valid low for 3 cycles between every byte. Expect:
  - exactly 2 pm_wren pulses;
  - busy=1 throughout;
  - done=1 at the end.
- Full depth: LEN=0, data[k]=k for k=0..255, CHK=0x80. Expect:
  - 256 writes with addr 0..255;
  - pm_wr_addr ends at 255 and the internal addr wraps to 0;
  - done=1.
- start during load: assert start mid-LOAD of LEN=4. Expect it ignored, with 4 writes at addresses 0..3.
- Async reset mid-load: assert reset between the 2nd and 3rd data byte. Expect, in the same cycle:
  - pm_wren=0, cpu_reset=1, busy=0, done=0, error=0.
  
  Then a fresh start with LEN=1, 0x0F, CHK=0xF1 gives done=1.

Source files
------------

// File: rtl/pm_loader_pkg.sv
// Shared types and constants for the program-memory loader.
package pm_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEN   = 2'd1,
    LOAD  = 2'd2,
    CHECK = 2'd3
  } state_e;

  // A LEN byte of this value requests a full-depth load
  localparam int unsigned LEN_FULL_DEPTH = 0;
  // A correct checksum makes (sum + CHK) wrap to this value
  localparam int unsigned CHK_OK         = 0;

endpackage

// File: rtl/pm_loader.sv
// Streams LEN / data / CHK bytes from the host into program memory and
// holds the processor in reset until the additive checksum passes.
module pm_loader
  import pm_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] pm_wr_addr,
  output logic [DATA_W-1:0] pm_wr_data,
  output logic              pm_wren,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Remaining count needs one extra bit to hold the full depth
  localparam int unsigned        REM_W  = ADDR_W + 1;
  localparam logic [REM_W-1:0]   FULL_N = REM_W'(1) << ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                wren_q, wren_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                rx_ready_q, rx_ready_d;
  logic                busy_q, busy_d;
  logic                xfer_c;
  logic [DATA_W-1:0]   chk_sum_c;

  assign xfer_c    = rx_valid & rx_ready_q;
  assign chk_sum_c = sum_q + rx_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      sum_q       <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wren_q      <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      sum_q       <= sum_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wren_q      <= wren_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    sum_d       = sum_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wren_d      = 1'b0;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LEN;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          sum_d       = '0;
          addr_d      = '0;
        end
      end
      LEN: begin
        if (xfer_c) begin
          rem_d   = (rx_data == DATA_W'(LEN_FULL_DEPTH)) ? FULL_N : REM_W'(rx_data);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (xfer_c) begin
          wren_d    = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = rx_data;
          addr_d    = addr_q + ADDR_W'(1);
          sum_d     = chk_sum_c;
          rem_d     = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) state_d = CHECK;
        end
      end
      CHECK: begin
        if (xfer_c) begin
          state_d = IDLE;
          if (chk_sum_c == DATA_W'(CHK_OK)) begin
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready/busy are registered decodes of the next state
    rx_ready_d = (state_d != IDLE);
    busy_d     = (state_d != IDLE);
  end

  assign rx_ready   = rx_ready_q;
  assign pm_wr_addr = wr_addr_q;
  assign pm_wr_data = wr_data_q;
  assign pm_wren    = wren_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_pm_loader.sv
// Scoreboard bench for pm_loader: expected writes queued at stimulus time,
// popped and compared as pm_wren pulses appear.
module tb_pm_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] pm_wr_addr;
  logic [7:0] pm_wr_data;
  logic       pm_wren;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       error;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  logic [15:0] sb_q[$];
  logic [7:0]  payload[$];
  logic [7:0]  exp_addr;

  pm_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .pm_wr_addr(pm_wr_addr), .pm_wr_data(pm_wr_data), .pm_wren(pm_wren),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every write pulse is matched against the next queued (addr,data)
  always @(negedge clk) begin
    if (!reset && pm_wren) begin
      wr_cnt++;
      if (sb_q.size() == 0) begin
        check("wr_unexpected", {pm_wr_addr, pm_wr_data}, 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = sb_q.pop_front();
        check("wr_addr", pm_wr_addr, e[15:8]);
        check("wr_data", pm_wr_data, e[7:0]);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drive one byte after `gap` idle cycles; is_data flags a LOAD-phase byte
  task automatic send_byte(input logic [7:0] b, input int gap, input bit is_data);
    int n;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      check("gap_busy", busy, 1);
      check("gap_wren", pm_wren, 0);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rx_ready) check("ready_timeout", rx_ready, 1);
    if (is_data) begin
      sb_q.push_back({exp_addr, b});
      exp_addr++;
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (is_data) check("wren_latency", pm_wren, 1);
  endtask

  task automatic run_load(input logic [7:0] len, input logic [7:0] chk, input int gap);
    exp_addr = 8'd0;
    pulse_start();
    check("start_cpu_reset", cpu_reset, 1);
    check("start_done_clr", done, 0);
    check("start_error_clr", error, 0);
    check("start_busy", busy, 1);
    send_byte(len, 0, 1'b0);
    foreach (payload[i]) send_byte(payload[i], gap, 1'b1);
    send_byte(chk, gap, 1'b0);
    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
  endtask

  task automatic check_result(input string tag, input bit exp_done, input int exp_wr);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, !exp_done);
    check({tag, "_cpu_reset"}, cpu_reset, !exp_done);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_wr_cnt"}, wr_cnt, exp_wr);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", rx_ready, 0);
    check("rst_wren", pm_wren, 0);
    check("rst_addr", pm_wr_addr, 0);
    check("rst_data", pm_wr_data, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Valid high in IDLE is never accepted
    rx_data = 8'h99; rx_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ready", rx_ready, 0);
    rx_valid = 1'b0;

    // Basic load
    payload = '{8'h12, 8'h34, 8'h56};
    wr_cnt = 0;
    run_load(8'd3, 8'h64, 0);
    check_result("basic", 1'b1, 3);

    // Bad checksum
    wr_cnt = 0;
    run_load(8'd3, 8'h65, 0);
    check_result("badchk", 1'b0, 3);

    // Handshake stalls between every byte
    payload = '{8'hA0, 8'h60};
    wr_cnt = 0;
    run_load(8'd2, 8'h00, 3);
    check_result("stall", 1'b1, 2);

    // Full depth with address wrap
    payload.delete();
    for (int k = 0; k < 256; k++) payload.push_back(8'(k));
    wr_cnt = 0;
    run_load(8'd0, 8'h80, 0);
    check_result("full", 1'b1, 256);
    check("full_last_addr", pm_wr_addr, 8'd255);
    check("full_addr_wrap", dut.addr_q, 8'd0);

    // start during LOAD is ignored
    wr_cnt = 0;
    exp_addr = 8'd0;
    pulse_start();
    send_byte(8'd4, 0, 1'b0);
    send_byte(8'h01, 0, 1'b1);
    send_byte(8'h02, 0, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("midstart_busy", busy, 1);
    send_byte(8'h03, 0, 1'b1);
    send_byte(8'h04, 0, 1'b1);
    send_byte(8'hF6, 0, 1'b0);
    @(negedge clk);
    check("midstart_sb", sb_q.size(), 0);
    check_result("midstart", 1'b1, 4);

    // Async reset with a write pulse in flight
    exp_addr = 8'd0;
    pulse_start();
    send_byte(8'd4, 0, 1'b0);
    send_byte(8'h11, 0, 1'b1);
    send_byte(8'h22, 0, 1'b1);
    reset = 1'b1;
    #1;
    check("arst_wren", pm_wren, 0);
    check("arst_cpu_reset", cpu_reset, 1);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_error", error, 0);
    check("arst_ready", rx_ready, 0);
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Fresh load after reset
    payload = '{8'h0F};
    wr_cnt = 0;
    run_load(8'd1, 8'hF1, 0);
    check_result("post_rst", 1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
